// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: pulls operand A, operand B and opcode from the UART RX FIFO,
// presents them to the ALU, and pushes the one-byte result into the TX FIFO.
// Illegal opcodes and inter-byte timeouts abort the frame and bump err_count.
module uart_alu_ctrl #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6,
    parameter int TIMEOUT = 1000,
    parameter int NB_TO   = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_empty,
    input  logic [NB_DATA-1:0] rx_data,
    output logic               rx_rd,
    input  logic               tx_full,
    output logic [NB_DATA-1:0] tx_data,
    output logic               tx_wr,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    output logic [NB_OP-1:0]   alu_op,
    input  logic [NB_DATA-1:0] alu_result,
    output logic               busy,
    output logic               op_err,
    output logic               to_err,
    output logic [7:0]         err_count
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SEND = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [NB_TO-1:0] to_cnt;
    logic             op_err_q;
    logic             to_err_q;
    logic             op_legal;
    logic             op_bad;
    logic             to_hit;
    logic             in_wait;

    // Opcode decode on the FIFO head byte (only meaningful in S_OP)
    always_comb begin
        case (rx_data[NB_OP-1:0])
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100),
            NB_OP'(6'b100101), NB_OP'(6'b100110), NB_OP'(6'b100111),
            NB_OP'(6'b000010), NB_OP'(6'b000011): op_legal = 1'b1;
            default:                              op_legal = 1'b0;
        endcase
    end

    assign in_wait = (state == S_B) || (state == S_OP);
    assign to_hit  = in_wait && rx_empty && (to_cnt == NB_TO'(TIMEOUT - 1));
    assign op_bad  = (state == S_OP) && !rx_empty && !op_legal;

    // Next-state logic and FIFO handshakes; both handshakes are held off during reset
    always_comb begin
        state_next = state;
        rx_rd      = 1'b0;
        tx_wr      = 1'b0;
        case (state)
            S_A: begin
                rx_rd = ~rx_empty;
                if (!rx_empty) state_next = S_B;
            end
            S_B: begin
                rx_rd = ~rx_empty;
                if (!rx_empty)  state_next = S_OP;
                else if (to_hit) state_next = S_A;
            end
            S_OP: begin
                rx_rd = ~rx_empty;
                if (!rx_empty)   state_next = op_legal ? S_EXEC : S_A;
                else if (to_hit) state_next = S_A;
            end
            S_EXEC: state_next = S_SEND;
            S_SEND: begin
                tx_wr = ~tx_full;
                if (!tx_full) state_next = S_A;
            end
            default: state_next = S_A;
        endcase
        if (!reset) begin
            rx_rd = 1'b0;
            tx_wr = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state <= S_A;
        else        state <= state_next;
    end

    // Operand/opcode capture, result capture, timeout counter and error bookkeeping
    always_ff @(posedge clk) begin
        if (!reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            tx_data   <= '0;
            err_count <= '0;
            to_cnt    <= '0;
            op_err_q  <= 1'b0;
            to_err_q  <= 1'b0;
        end else begin
            op_err_q <= op_bad;
            to_err_q <= to_hit;
            if ((op_bad || to_hit) && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;

            case (state)
                S_A:    if (!rx_empty) alu_a <= rx_data;
                S_B:    if (!rx_empty) alu_b <= rx_data;
                S_OP:   if (!rx_empty && op_legal) alu_op <= rx_data[NB_OP-1:0];
                S_EXEC: tx_data <= alu_result;
                default: ;
            endcase

            if (in_wait && rx_empty && !to_hit) to_cnt <= to_cnt + 1'b1;
            else                                 to_cnt <= '0;
        end
    end

    assign busy   = (state != S_A);
    assign op_err = op_err_q & reset;
    assign to_err = to_err_q & reset;

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: behavioural RX FIFO / TX FIFO / ALU around
// the DUT, hand-computed expected bytes, timings and error counts.
module tb_uart_alu_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_empty;
    logic [7:0] rx_data;
    logic       rx_rd;
    logic       tx_full;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [5:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    logic       op_err;
    logic       to_err;
    logic [7:0] err_count;

    int n_vec = 0;
    int n_err = 0;

    // RX FIFO model (first-word-fall-through)
    logic [7:0] rx_mem [0:255];
    logic [7:0] rd_ptr = '0;
    logic [7:0] wr_ptr = '0;
    logic       pop_pend = 1'b0;

    // Observation logs
    int         cyc = 0;
    int         n_pop = 0;
    int         n_push = 0;
    int         n_operr = 0;
    int         n_toerr = 0;
    int         pop_cyc [0:255];
    int         push_cyc [0:255];
    logic [7:0] push_data [0:255];

    always #5 clk = ~clk;

    assign rx_empty = (rd_ptr == wr_ptr);
    assign rx_data  = rx_mem[rd_ptr];

    function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h02:   return a >> b[2:0];
            6'h03:   return 8'($signed(a) >>> b[2:0]);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_op);

    uart_alu_ctrl #(
        .NB_DATA(8),
        .NB_OP  (6),
        .TIMEOUT(16),
        .NB_TO  (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_empty  (rx_empty),
        .rx_data   (rx_data),
        .rx_rd     (rx_rd),
        .tx_full   (tx_full),
        .tx_data   (tx_data),
        .tx_wr     (tx_wr),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_result(alu_result),
        .busy      (busy),
        .op_err    (op_err),
        .to_err    (to_err),
        .err_count (err_count)
    );

    // Mid-cycle observation of handshakes and error pulses
    always @(negedge clk) begin
        pop_pend = rx_rd;
        if (rx_rd) begin
            pop_cyc[n_pop] = cyc;
            n_pop++;
        end
        if (tx_wr) begin
            push_cyc[n_push]  = cyc;
            push_data[n_push] = tx_data;
            n_push++;
        end
        if (op_err) n_operr++;
        if (to_err) n_toerr++;
    end

    // RX FIFO pop takes effect on the edge that consumes the head word
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pop_pend) rd_ptr <= rd_ptr + 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    int p0, q0, e0;

    initial begin
        reset   = 1'b0;
        tx_full = 1'b0;
        tick(2);
        check("rst_busy",   32'(busy), 0);
        check("rst_alu_a",  32'(alu_a), 0);
        check("rst_alu_op", 32'(alu_op), 0);
        check("rst_tx_data",32'(tx_data), 0);
        check("rst_errcnt", 32'(err_count), 0);
        check("rst_tx_wr",  32'(tx_wr), 0);
        reset = 1'b1;
        tick(1);

        // 1: ADD 5 + 3
        p0 = n_push; q0 = n_pop;
        push_rx(8'h05); push_rx(8'h03); push_rx(8'h20);
        tick(8);
        check("t1_pops",    32'(n_pop - q0), 3);
        check("t1_alu_a",   32'(alu_a), 32'h05);
        check("t1_alu_b",   32'(alu_b), 32'h03);
        check("t1_pushes",  32'(n_push - p0), 1);
        check("t1_result",  32'(push_data[p0]), 32'h08);
        check("t1_latency", 32'(push_cyc[p0] - pop_cyc[q0 + 2]), 2);
        check("t1_busy",    32'(busy), 0);

        // 2: XOR with TX full for 20 cycles
        p0 = n_push; e0 = n_toerr;
        tx_full = 1'b1;
        push_rx(8'h0F); push_rx(8'hF0); push_rx(8'h26);
        tick(5);
        for (int i = 0; i < 20; i++) begin
            check("t2_hold_wr",   32'(tx_wr), 0);
            check("t2_hold_data", 32'(tx_data), 32'hFF);
            tick(1);
        end
        check("t2_busy_held", 32'(busy), 1);
        check("t2_no_to_err", 32'(n_toerr - e0), 0);
        tx_full = 1'b0;
        tick(2);
        check("t2_pushes", 32'(n_push - p0), 1);
        check("t2_result", 32'(push_data[p0]), 32'hFF);

        // 3: illegal opcode, then SUB
        p0 = n_push; q0 = n_pop; e0 = n_operr;
        push_rx(8'h01); push_rx(8'h02); push_rx(8'h3F);
        tick(6);
        check("t3_pops",      32'(n_pop - q0), 3);
        check("t3_op_err",    32'(n_operr - e0), 1);
        check("t3_errcnt",    32'(err_count), 1);
        check("t3_no_push",   32'(n_push - p0), 0);
        check("t3_alu_op",    32'(alu_op), 32'h26);
        check("t3_busy",      32'(busy), 0);
        push_rx(8'h07); push_rx(8'h01); push_rx(8'h22);
        tick(8);
        check("t3_sub_push",  32'(n_push - p0), 1);
        check("t3_sub_res",   32'(push_data[p0]), 32'h06);

        // 4: inter-byte timeout after operand A
        e0 = n_toerr;
        push_rx(8'h11);
        tick(16);
        check("t4_busy_pre",  32'(busy), 1);
        check("t4_to_pre",    32'(to_err), 0);
        tick(1);
        check("t4_busy_post", 32'(busy), 0);
        check("t4_to_pulse",  32'(to_err), 1);
        tick(1);
        check("t4_to_done",   32'(to_err), 0);
        check("t4_to_count",  32'(n_toerr - e0), 1);
        check("t4_errcnt",    32'(err_count), 2);
        p0 = n_push;
        push_rx(8'h0C); push_rx(8'h0A); push_rx(8'h25);
        tick(8);
        check("t4_or_push",   32'(n_push - p0), 1);
        check("t4_or_res",    32'(push_data[p0]), 32'h0E);

        // 5: three frames back to back
        p0 = n_push; q0 = n_pop;
        push_rx(8'h10); push_rx(8'h22); push_rx(8'h20);
        push_rx(8'hF3); push_rx(8'h3C); push_rx(8'h24);
        push_rx(8'h80); push_rx(8'h03); push_rx(8'h02);
        tick(20);
        check("t5_pops",   32'(n_pop - q0), 9);
        check("t5_pushes", 32'(n_push - p0), 3);
        check("t5_add",    32'(push_data[p0]), 32'h32);
        check("t5_and",    32'(push_data[p0 + 1]), 32'h30);
        check("t5_srl",    32'(push_data[p0 + 2]), 32'h10);
        check("t5_gap1",   32'(pop_cyc[q0 + 3] - push_cyc[p0]), 1);
        check("t5_gap2",   32'(pop_cyc[q0 + 6] - push_cyc[p0 + 1]), 1);

        // 6: reset while in S_OP with the opcode waiting
        p0 = n_push; q0 = n_pop;
        push_rx(8'h09); push_rx(8'h04); push_rx(8'h20);
        tick(2);
        check("t6_in_op",     32'(busy), 1);
        reset = 1'b0;
        #1;
        check("t6_rd_gated",  32'(rx_rd), 0);
        tick(1);
        check("t6_busy",      32'(busy), 0);
        check("t6_alu_a",     32'(alu_a), 0);
        check("t6_alu_b",     32'(alu_b), 0);
        check("t6_alu_op",    32'(alu_op), 0);
        check("t6_errcnt",    32'(err_count), 0);
        check("t6_pops",      32'(n_pop - q0), 2);
        reset = 1'b1;
        push_rx(8'h03); push_rx(8'h20);
        tick(8);
        check("t6_new_a",     32'(alu_a), 32'h20);
        check("t6_new_b",     32'(alu_b), 32'h03);
        check("t6_push",      32'(n_push - p0), 1);
        check("t6_res",       32'(push_data[p0]), 32'h23);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_alu_ctrl.md
Name: uart_alu_ctrl

Overview:
Sequencer between the UART RX FIFO, the ALU and the UART TX FIFO.
- Pops three bytes from the RX FIFO in order: operand A, operand B, opcode.
- Drives the ALU with those values, captures the result and pushes it as one byte into the TX FIFO.
- Rejects illegal opcodes and aborts partial frames on an inter-byte timeout.

Parameters:
NB_DATA, 8, data/operand/result width in bits (equals FIFO word width)
NB_OP, 6, ALU opcode width; opcode taken from rx_data[NB_OP-1:0]
TIMEOUT, 1000, max idle cycles allowed between bytes of one frame
NB_TO, 10, timeout counter width (2**NB_TO > TIMEOUT)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset; 0 = reset asserted, sampled on rising clk
rx_empty  in  1  RX FIFO empty flag
rx_data  in  NB_DATA  RX FIFO head word; first-word-fall-through, valid while rx_empty=0
rx_rd  out  1  pop RX FIFO head this cycle
tx_full  in  1  TX FIFO full flag
tx_data  out  NB_DATA  word to write into TX FIFO
tx_wr  out  1  write tx_data into TX FIFO this cycle
alu_a  out  NB_DATA  registered operand A
alu_b  out  NB_DATA  registered operand B
alu_op  out  NB_OP  registered opcode
alu_result  in  NB_DATA  combinational ALU result
busy  out  1  1 whenever state != S_A
op_err  out  1  one-cycle pulse on illegal opcode
to_err  out  1  one-cycle pulse on timeout abort
err_count  out  8  saturating count of op_err plus to_err events

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=S_A; alu_a, alu_b, alu_op, tx_data, err_count and the timeout counter all cleared to 0.
  - rx_rd, tx_wr, op_err and to_err forced to 0 while reset=0, regardless of FIFO flags.
  - Reset mid-frame discards the partial frame. No pop or push occurs in the reset cycle.
- States: S_A, S_B, S_OP, S_EXEC, S_SEND.
- S_A, S_B, S_OP (byte-fetch states):
  - rx_rd = ~rx_empty (combinational).
  - When rx_empty=0: latch rx_data into alu_a / alu_b / alu_op respectively, advance to the next state, clear the timeout counter.
  - Exactly one pop per accepted byte.
- Opcode check in S_OP: legal values are 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000010 SRL, 000011 SRA.
  - Illegal: byte is still popped, op_err pulses in the cycle after the pop, err_count increments, next state is S_A, alu_op keeps its previous value.
- S_EXEC: lasts one cycle.
  - alu_result is registered into tx_data at the end of the cycle (ALU inputs have been stable for a full cycle).
  - Next state is S_SEND.
- S_SEND:
  - tx_wr = ~tx_full (combinational).
  - When tx_full=0: push and go to S_A. When tx_full=1: hold with tx_data stable; no loss, no timeout.
- Latency: opcode pop at cycle t -> S_EXEC at t+1 -> tx_wr at t+2 (if TX not full).
- Timeout: applies only in S_B and S_OP.
  - Counter increments each cycle rx_empty=1; clears on an accepted byte.
  - When it reaches TIMEOUT-1 with rx_empty still 1: next state is S_A, to_err pulses one cycle, err_count increments.
  - S_A waits forever.
- err_count saturates at 255.
  - op_err and to_err are mutually exclusive by construction; increment is at most 1 per cycle.
- No combinational path from rx_data or alu_result to outputs. rx_rd depends only on state and rx_empty; tx_wr only on state and tx_full.
- Back-to-back frames: a new byte may be popped in S_A in the cycle immediately after the push.

Test Plan:
1. RX holds 0x05, 0x03, 0x20 (ADD); ALU model adds -> exactly 3 rx_rd pulses, alu_a=0x05, alu_b=0x03, tx_wr once with tx_data=0x08 two cycles after the opcode pop; busy returns to 0.
2. Frame 0x0F, 0xF0, 0x26 (XOR) with tx_full=1 for 20 cycles -> stays in S_SEND, tx_wr=0, tx_data=0xFF stable, no to_err; tx_full drops -> single tx_wr with 0xFF.
3. Frame 0x01, 0x02, 0x3F (illegal) -> third byte popped, op_err single pulse, err_count=1, no tx_wr, next frame 0x07, 0x01, 0x22 (SUB) yields 0x06.
4. Send only 0x11, then leave RX empty, TIMEOUT=16 -> to_err pulses after 16 idle cycles, err_count increments, state S_A; next full frame processed correctly.
5. Three frames preloaded back-to-back (ADD, AND, SRL) -> 9 pops, 3 pushes in order, no idle cycle between push and next pop.
6. reset=0 for one cycle while in S_OP with RX non-empty -> rx_rd=0 that cycle, alu_a/alu_b/alu_op=0, err_count=0, state S_A; the remaining RX byte is treated as new operand A.
